// File: rtl/rr_pkg.sv
// Shared definitions for the round-robin arbiter family: server state encoding
// and the index-width helper used to size client ids.
package rr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    ACK  = 2'd2,
    GAP  = 2'd3
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  localparam int RR_WIDTH = 4;
  localparam int ID_W     = clog2(RR_WIDTH);

endpackage

// File: rtl/rr_grant_server_if.sv
// Arbiter-side grant/ack/descriptor signals plus the downstream beat stream.
interface rr_grant_server_if
  import rr_pkg::*;
#(
  parameter int WIDTH  = RR_WIDTH,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4
) ();

  localparam int IDX_W = clog2(WIDTH);

  logic [WIDTH-1:0]        grant;
  logic                    ack;
  logic [WIDTH*DATA_W-1:0] req_data;
  logic [WIDTH*LEN_W-1:0]  req_len;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_W-1:0]       out_data;
  logic                    out_last;
  logic [IDX_W-1:0]        out_id;
  logic [WIDTH-1:0]        done;
  logic                    busy;
  logic                    err_multi;

  modport master (
    output grant, req_data, req_len, out_ready,
    input  ack, out_valid, out_data, out_last, out_id, done, busy, err_multi
  );

  modport slave (
    input  grant, req_data, req_len, out_ready,
    output ack, out_valid, out_data, out_last, out_id, done, busy, err_multi
  );

endinterface

// File: rtl/rr_onehot_enc.sv
// One-hot to binary encoder with nonzero and multi-hot detection.
module rr_onehot_enc
  import rr_pkg::*;
#(
  parameter int WIDTH = RR_WIDTH,
  parameter int IDX_W = clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             any,
  output logic             multi
);

  // OR of set-bit positions: exact for one-hot input, meaningless otherwise.
  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (vec[i]) idx = idx | IDX_W'(i);
    end
  end

  assign any   = |vec;
  assign multi = |(vec & (vec - WIDTH'(1)));

endmodule

// File: rtl/rr_grant_server.sv
// Serves one granted client at a time: latches its descriptor, streams the
// burst on valid/ready, then pulses ack/done so the arbiter can rotate.
module rr_grant_server
  import rr_pkg::*;
#(
  parameter int WIDTH  = RR_WIDTH,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4
) (
  input logic              clk,
  input logic              resetb,
  rr_grant_server_if.slave bus
);

  localparam int IDX_W = clog2(WIDTH);

  state_e              r_state, w_state;
  logic [LEN_W-1:0]    r_len, w_len;
  logic [LEN_W-1:0]    r_beat, w_beat;
  logic                r_out_valid, w_out_valid;
  logic [DATA_W-1:0]   r_out_data, w_out_data;
  logic                r_out_last, w_out_last;
  logic [IDX_W-1:0]    r_out_id, w_out_id;
  logic                r_ack, w_ack;
  logic [WIDTH-1:0]    r_done, w_done;
  logic                r_busy, w_busy;
  logic                r_err, w_err;

  logic [IDX_W-1:0]    w_idx;
  logic                w_any;
  logic                w_multi;
  logic [DATA_W-1:0]   w_sel_data;
  logic [LEN_W-1:0]    w_sel_len;
  logic [LEN_W-1:0]    w_beat_nxt;
  logic [WIDTH-1:0]    w_id_onehot;

  rr_onehot_enc #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_enc (
    .vec   (bus.grant),
    .idx   (w_idx),
    .any   (w_any),
    .multi (w_multi)
  );

  assign w_sel_data  = bus.req_data[int'(w_idx)*DATA_W +: DATA_W];
  assign w_sel_len   = bus.req_len[int'(w_idx)*LEN_W +: LEN_W];
  assign w_beat_nxt  = r_beat + LEN_W'(1);
  assign w_id_onehot = WIDTH'(1) << r_out_id;

  // The descriptor is latched straight into out_id/out_data; later beats
  // increment out_data, which equals base + beat modulo 2^DATA_W.
  always_comb begin
    // NOTE: every w_ signal gets a default first so no latch is inferred.
    w_state     = r_state;
    w_len       = r_len;
    w_beat      = r_beat;
    w_out_valid = r_out_valid;
    w_out_data  = r_out_data;
    w_out_last  = r_out_last;
    w_out_id    = r_out_id;
    w_busy      = r_busy;
    w_ack       = 1'b0;
    w_done      = '0;
    w_err       = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_multi) begin
          w_err = 1'b1;
        end else if (w_any) begin
          w_out_id   = w_idx;
          w_out_data = w_sel_data;
          w_len      = w_sel_len;
          w_beat     = '0;
          w_busy     = 1'b1;
          w_state    = (w_sel_len != '0) ? XFER : ACK;
        end
      end
      XFER: begin
        if (!r_out_valid) begin
          w_out_valid = 1'b1;
          w_out_last  = (r_len == LEN_W'(1));
        end else if (bus.out_ready) begin
          w_beat = w_beat_nxt;
          if (r_out_last) begin
            w_out_valid = 1'b0;
            w_out_last  = 1'b0;
            w_ack       = 1'b1;
            w_done      = w_id_onehot;
            w_state     = ACK;
          end else begin
            w_out_data = r_out_data + DATA_W'(1);
            w_out_last = (w_beat_nxt == r_len - LEN_W'(1));
          end
        end
      end
      // Arriving from XFER the pulse is already up; a zero-length burst
      // enters with it low and raises it here first.
      ACK: begin
        if (r_ack) begin
          w_state = GAP;
        end else begin
          w_ack  = 1'b1;
          w_done = w_id_onehot;
        end
      end
      GAP: begin
        w_state = IDLE;
        w_busy  = 1'b0;
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_state     <= IDLE;
      r_len       <= '0;
      r_beat      <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_id    <= '0;
      r_ack       <= 1'b0;
      r_done      <= '0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register updates from pre-edge values.
      r_state     <= w_state;
      r_len       <= w_len;
      r_beat      <= w_beat;
      r_out_valid <= w_out_valid;
      r_out_data  <= w_out_data;
      r_out_last  <= w_out_last;
      r_out_id    <= w_out_id;
      r_ack       <= w_ack;
      r_done      <= w_done;
      r_busy      <= w_busy;
      r_err       <= w_err;
    end
  end

  assign bus.ack       = r_ack;
  assign bus.done      = r_done;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_last  = r_out_last;
  assign bus.out_id    = r_out_id;
  assign bus.busy      = r_busy;
  assign bus.err_multi = r_err;

endmodule

// File: tb/tb_rr_grant_server.sv
// Directed bench for rr_grant_server: a timestamp-based burst model checked
// every cycle, plus literal expectations for each scenario.
module tb_rr_grant_server;

  localparam int W  = 4;
  localparam int DW = 8;
  localparam int LW = 4;

  logic clk;
  logic resetb;

  rr_grant_server_if #(.WIDTH(W), .DATA_W(DW), .LEN_W(LW)) bus ();

  rr_grant_server #(.WIDTH(W), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk    (clk),
    .resetb (resetb),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  bit cmp_on  = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int first_one(input logic [W-1:0] v);
    for (int i = 0; i < W; i++) if (v[i]) return i;
    return -1;
  endfunction

  // ---------------- behavioural model (edge timestamps) ----------------
  int              t = 0;
  bit              m_job;
  int              m_id, m_len, m_sent, m_t0, m_ack_t;
  logic [DW-1:0]   m_base;
  logic [DW-1:0]   e_data;
  bit              e_valid, e_ack, e_busy, e_err;
  logic [W-1:0]    e_done;

  always @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      m_job = 0; m_sent = 0; m_len = 0; m_id = 0; m_ack_t = -100; m_t0 = -100;
      e_valid = 0; e_ack = 0; e_busy = 0; e_err = 0; e_done = '0;
    end else begin
      t++;
      e_ack = 0; e_err = 0; e_done = '0;
      if (!m_job) begin
        if ($countones(bus.grant) > 1) begin
          e_err = 1;
        end else if (bus.grant != '0) begin
          m_job   = 1;
          m_id    = first_one(bus.grant);
          m_base  = bus.req_data[m_id*DW +: DW];
          m_len   = int'(bus.req_len[m_id*LW +: LW]);
          m_sent  = 0;
          m_t0    = t;
          m_ack_t = (m_len == 0) ? t + 1 : -100;
          e_busy  = 1;
        end
      end else begin
        if (e_valid && bus.out_ready) begin
          m_sent++;
          if (m_sent == m_len) begin
            e_valid = 0;
            m_ack_t = t;
          end
        end else if (t == m_t0 + 1 && m_len != 0) begin
          e_valid = 1;
        end
        if (t == m_ack_t) begin
          e_ack = 1;
          e_done[m_id] = 1'b1;
        end
        if (t == m_ack_t + 2) begin
          m_job  = 0;
          e_busy = 0;
        end
      end
      e_data = m_base + DW'(m_sent);
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      check("ack", bus.ack, e_ack);
      check("done", bus.done, e_done);
      check("busy", bus.busy, e_busy);
      check("err_multi", bus.err_multi, e_err);
      check("out_valid", bus.out_valid, e_valid);
      check("out_last", bus.out_last, e_valid && (m_sent == m_len - 1));
      if (e_valid) begin
        check("out_data", bus.out_data, e_data);
        check("out_id", bus.out_id, m_id);
      end
    end
  end

  // ---------------- directed scenarios ----------------
  logic [DW-1:0] q_data[$];
  bit            q_last[$];
  int            ack_k, ack_cnt, valid_cnt, err_cnt;
  logic [W-1:0]  done_seen;

  task automatic run_burst(input logic [W-1:0] g, input bit toggle, input bit one_shot,
                           input bit mutate, input int max_k);
    q_data.delete(); q_last.delete();
    ack_k = -1; ack_cnt = 0; valid_cnt = 0; err_cnt = 0; done_seen = '0;
    @(negedge clk);
    bus.grant = g;
    for (int k = 1; k <= max_k; k++) begin
      @(negedge clk);
      if (one_shot && k == 1) bus.grant = '0;
      if (mutate && k == 3) begin
        bus.req_data = ~bus.req_data;
        bus.req_len  = ~bus.req_len;
        bus.grant    = 4'b0010;
      end
      if (toggle) bus.out_ready = ((k % 2) == 1);
      if (bus.out_valid) valid_cnt++;
      if (bus.out_valid && bus.out_ready) begin
        q_data.push_back(bus.out_data);
        q_last.push_back(bus.out_last);
      end
      if (bus.err_multi) err_cnt++;
      if (bus.ack) begin
        ack_cnt++;
        if (ack_k < 0) begin
          ack_k     = k;
          done_seen = bus.done;
        end
        bus.grant = '0;
      end
    end
    if (ack_k < 0 && !one_shot) check("ack_within_budget", 0, 1);
  endtask

  task automatic check_beats(input string nm, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                             input logic [DW-1:0] d2, input int n);
    logic [DW-1:0] exp_d [3];
    exp_d[0] = d0; exp_d[1] = d1; exp_d[2] = d2;
    check({nm, "_beat_count"}, q_data.size(), n);
    for (int i = 0; i < n && i < q_data.size(); i++) begin
      check($sformatf("%s_beat%0d_data", nm, i), q_data[i], exp_d[i]);
      check($sformatf("%s_beat%0d_last", nm, i), q_last[i], (i == n - 1));
    end
  endtask

  logic [W-1:0] rr_req;
  int           rr_ptr, rr_g, rr_acks;
  int           served[$];

  function automatic int rr_pick(input logic [W-1:0] r, input int p);
    for (int i = 0; i < W; i++) begin
      int c;
      c = (p + i) % W;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  initial begin
    int acks_after;
    resetb        = 1'b1;
    bus.grant     = '0;
    bus.req_data  = '0;
    bus.req_len   = '0;
    bus.out_ready = 1'b0;
    #1 resetb = 1'b0;
    cmp_on = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_id", bus.out_id, 0);
    check("rst_busy", bus.busy, 0);
    #2 resetb = 1'b1;

    // Single burst; descriptor and grant changes mid-burst must be ignored.
    bus.req_data[0*DW +: DW] = 8'h10;
    bus.req_len[0*LW +: LW]  = 4'd3;
    bus.out_ready = 1'b1;
    run_burst(4'b0001, 1'b0, 1'b0, 1'b1, 10);
    check_beats("single", 8'h10, 8'h11, 8'h12, 3);
    check("single_ack_cycle", ack_k, 5);
    check("single_ack_count", ack_cnt, 1);
    check("single_done", done_seen, 4'b0001);

    // Backpressure with out_ready toggling.
    bus.grant    = '0;
    bus.req_data = '0;
    bus.req_len  = '0;
    bus.req_data[2*DW +: DW] = 8'hA0;
    bus.req_len[2*LW +: LW]  = 4'd2;
    run_burst(4'b0100, 1'b1, 1'b0, 1'b0, 10);
    check_beats("bp", 8'hA0, 8'hA1, 8'h00, 2);
    check("bp_valid_cycles", valid_cnt, 4);
    check("bp_ack_cycle", ack_k, 6);
    check("bp_done", done_seen, 4'b0100);
    check("bp_ack_count", ack_cnt, 1);

    // Zero-length burst.
    bus.out_ready = 1'b1;
    bus.req_data[3*DW +: DW] = 8'h77;
    bus.req_len[3*LW +: LW]  = 4'd0;
    run_burst(4'b1000, 1'b0, 1'b0, 1'b0, 8);
    check("zero_valid_cycles", valid_cnt, 0);
    check("zero_ack_cycle", ack_k, 2);
    check("zero_done", done_seen, 4'b1000);
    check("zero_ack_count", ack_cnt, 1);

    // Multi-hot grant presented for a single edge.
    run_burst(4'b0110, 1'b0, 1'b1, 1'b0, 8);
    check("multi_err_pulses", err_cnt, 1);
    check("multi_ack_count", ack_cnt, 0);
    check("multi_valid_cycles", valid_cnt, 0);
    check("multi_busy", bus.busy, 0);

    // Reset in the middle of a burst.
    bus.req_data[0*DW +: DW] = 8'h10;
    bus.req_len[0*LW +: LW]  = 4'd3;
    @(negedge clk);
    bus.grant = 4'b0001;
    repeat (3) @(negedge clk);
    check("midrst_valid_before", bus.out_valid, 1);
    #2 resetb = 1'b0;
    bus.grant = '0;
    #1;
    check("midrst_valid", bus.out_valid, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_ack", bus.ack, 0);
    check("midrst_done", bus.done, 0);
    @(negedge clk);
    #2 resetb = 1'b1;
    acks_after = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.ack) acks_after++;
    end
    check("midrst_no_ack", acks_after, 0);

    // Round-robin partner: clients 0..2 request, each drops on its done.
    for (int i = 0; i < W; i++) begin
      bus.req_data[i*DW +: DW] = DW'(8'h40 + i);
      bus.req_len[i*LW +: LW]  = 4'd1;
    end
    rr_req  = 4'b0111;
    rr_ptr  = 0;
    rr_acks = 0;
    served.delete();
    @(negedge clk);
    rr_g = rr_pick(rr_req, rr_ptr);
    bus.grant = '0;
    bus.grant[rr_g] = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (bus.ack) begin
        rr_acks++;
        served.push_back(first_one(bus.done));
        rr_req = rr_req & ~bus.done;
        rr_ptr = (rr_g + 1) % W;
        rr_g   = rr_pick(rr_req, rr_ptr);
        bus.grant = '0;
        if (rr_g >= 0) bus.grant[rr_g] = 1'b1;
      end
    end
    check("rr_ack_count", rr_acks, 3);
    check("rr_served_count", served.size(), 3);
    for (int i = 0; i < 3 && i < served.size(); i++)
      check($sformatf("rr_order%0d", i), served[i], i);

    cmp_on = 1'b0;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

endmodule

// File: doc/rr_grant_server.md
Name: rr_grant_server

Overview:
Resource-side partner of rr_arbiter. It consumes the arbiter's one-hot grant vector and latches the granted client's burst descriptor (base data, length). It streams the burst on a valid/ready output, then returns a one-cycle ack pulse so the arbiter rotates to the next requester. It sits between rr_arbiter and the shared downstream resource.

Parameters:
WIDTH, 4, number of clients; must match rr_arbiter WIDTH
DATA_W, 8, beat data width
LEN_W, 4, burst length field width; max burst 2^LEN_W-1 beats

Ports:
clk  in  1  single clock, rising edge
resetb  in  1  asynchronous reset, active-low
grant  in  WIDTH  one-hot grant from rr_arbiter; all-zero means no grant
ack  out  1  one-cycle pulse to rr_arbiter when the granted burst completes
req_data  in  WIDTH*DATA_W  per-client base data; client i in bits [i*DATA_W +: DATA_W]
req_len  in  WIDTH*LEN_W  per-client beat count; client i in bits [i*LEN_W +: LEN_W]
out_valid  out  1  beat valid
out_ready  in  1  downstream accepts beat
out_data  out  DATA_W  beat payload
out_last  out  1  final beat of burst
out_id  out  clog2(WIDTH)  index of the client being served
done  out  WIDTH  one-cycle pulse on the served client's bit, concurrent with ack
busy  out  1  high in every state except IDLE
err_multi  out  1  one-cycle pulse when grant is multi-hot in IDLE

Behaviour:
- Reset (resetb=0, async) puts the FSM in IDLE. ack, out_valid, out_last, done, busy and err_multi go 0 immediately; out_data and out_id go 0; beat counter clears.
- All outputs are registered.
- FSM states: IDLE, XFER, ACK, GAP.
- IDLE with grant one-hot: latch id, data = req_data[id] and len = req_len[id], clear beat counter.
  - If len != 0, go to XFER.
  - If len == 0, go directly to ACK; no beats are emitted.
- IDLE with grant multi-hot: pulse err_multi for one cycle, latch nothing, stay in IDLE.
- IDLE with grant == 0: stay in IDLE.
- XFER:
  - out_valid = 1, out_data = latched data + beat (mod 2^DATA_W), out_id = latched id.
  - out_last = 1 when beat == len-1.
  - On out_valid && out_ready: beat increments. If that beat was the last one, clear out_valid and go to ACK.
  - out_data, out_last and out_id are held stable while out_ready = 0.
  - grant, req_data and req_len changes are ignored (values stay latched).
- ACK: ack = 1 and done[id] = 1 for exactly one cycle, then go to GAP.
- GAP: one cycle that ignores grant while rr_arbiter registers the rotated grant. Then go to IDLE.
- Latency:
  - Grant sampled at edge N: first beat is valid after edge N+1.
  - Burst of L beats with out_ready held at 1: ack is high in the cycle after edge N+L+1.
  - Minimum spacing between consecutive grant samples is L+3 cycles (L=0 gives 3).
- Client contract: the client must drop its request bit on its done pulse, or it will be served again on its next turn. This is legal and not an error.
- Reset mid-burst: the burst is aborted, no ack and no done are issued, and the FSM restarts in IDLE.

Decomposition:
- Shared package rr_pkg:
  - state enum (IDLE, XFER, ACK, GAP)
  - clog2 constant function
  - ID_W = clog2(WIDTH) convention shared with rr_arbiter
- One sub-module, rr_onehot_enc:
  - combinational one-hot to binary encoder
  - outputs: idx, any (nonzero) and multi (more than one bit set)
  - reused later by other arbiter-side blocks

Test Plan:
- Reset: resetb=0 while a burst is in progress -> out_valid, ack, done and busy drop to 0 in the same cycle; no ack follows reset release.
- Single burst: grant=0001, req_len[0]=3, req_data[0]=8'h10, out_ready=1 -> beats 10,11,12 with out_last on 12 and out_id=0; ack and done=0001 pulse one cycle later; then 1 cycle in GAP.
- Backpressure: grant=0100, len=2, out_ready toggling 0/1 every cycle -> data and out_last stable while stalled; exactly 2 beats; ack only after the second handshake.
- Zero length: grant=1000, req_len[3]=0 -> no out_valid; ack and done=1000 follow the grant sample by exactly 2 cycles.
- Multi-hot: grant=0110 in IDLE -> err_multi pulses once; no latch, no beats, no ack; FSM stays IDLE.
- Integration with rr_arbiter: request=0111, each len=1, client drops its request on done -> grants served in round-robin order 0,1,2 with one ack per burst and no duplicated service.
